// File: rtl/spm_seq_ctrl.sv
// Operand/product sequencer around a serial/parallel multiplier array:
// holds a on the array, streams x LSB first, then collects the serial product.
module spm_seq_ctrl #(
    parameter int unsigned bits   = 32,
    parameter int unsigned WARMUP = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [bits-1:0]   in_a,
    input  logic [bits-1:0]   in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*bits-1:0] out_p,
    output logic [bits-1:0]   mul_a,
    output logic              mul_x,
    input  logic              mul_y
);

    localparam int unsigned PW     = 2 * bits;
    localparam int unsigned CW_RUN = $clog2(PW + 2);
    localparam int unsigned CW_WU  = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int unsigned CW     = (CW_RUN > CW_WU) ? CW_RUN : CW_WU;

    typedef enum logic [1:0] {
        S_WARMUP,
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [bits-1:0] x_reg;
    logic [PW-1:0]   prod;
    logic            accept;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_WARMUP;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        in_ready  = 1'b0;
        accept    = 1'b0;
        unique case (state)
            S_WARMUP: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == CW'(WARMUP - 1)) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            end
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == CW'(PW)) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                end
            end
            S_DONE: begin
                if (out_valid && out_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_WARMUP;
        endcase
    end

    // out_p/out_valid load one cycle after the last product bit lands in prod,
    // so DONE always spends its first cycle publishing the result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mul_a     <= '0;
            mul_x     <= 1'b0;
            x_reg     <= '0;
            prod      <= '0;
            out_p     <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    mul_x <= 1'b0;
                    if (accept) begin
                        mul_a <= in_a;
                        mul_x <= in_x[0];
                        x_reg <= in_x >> 1;
                    end
                end
                S_RUN: begin
                    mul_x <= x_reg[0];
                    x_reg <= x_reg >> 1;
                    if (cnt != '0)
                        prod <= {mul_y, prod[PW-1:1]};
                end
                S_DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_p     <= prod;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    mul_x <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Directed and randomised checks of spm_seq_ctrl against a behavioural
// serial/parallel multiplier; instances at bits=32 and bits=8.
module tb_spm_seq_ctrl;

    localparam int unsigned WU = 3;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, mul_x, mul_y;
    logic [31:0] in_a = '0, in_x = '0, mul_a;
    logic [63:0] out_p;

    logic        in_valid8 = 1'b0, out_ready8 = 1'b0;
    logic        in_ready8, out_valid8, mul_x8, mul_y8;
    logic [7:0]  in_a8 = '0, in_x8 = '0, mul_a8;
    logic [15:0] out_p8;

    spm_seq_ctrl #(.bits(32), .WARMUP(WU)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_x(in_x), .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .mul_a(mul_a), .mul_x(mul_x), .mul_y(mul_y)
    );

    spm_seq_ctrl #(.bits(8), .WARMUP(WU)) dut8 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(in_a8), .in_x(in_x8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out_p(out_p8), .mul_a(mul_a8), .mul_x(mul_x8), .mul_y(mul_y8)
    );

    // Serial/parallel multiplier: y(t+1) = LSB of (carry state + x(t)*a)
    logic [32:0] m_sum;
    logic [31:0] m_s;
    assign m_sum = {1'b0, m_s} + (mul_x ? {1'b0, mul_a} : 33'd0);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_s   <= '0;
            mul_y <= 1'b0;
        end else begin
            m_s   <= m_sum[32:1];
            mul_y <= m_sum[0];
        end
    end

    logic [8:0] m_sum8;
    logic [7:0] m_s8;
    assign m_sum8 = {1'b0, m_s8} + (mul_x8 ? {1'b0, mul_a8} : 9'd0);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_s8   <= '0;
            mul_y8 <= 1'b0;
        end else begin
            m_s8   <= m_sum8[8:1];
            mul_y8 <= m_sum8[0];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] x, input int stall,
                          output logic [63:0] p, output int lat, output bit to);
        int n;
        n = 0; lat = 0; p = '0; to = 1'b0;
        while (!in_ready && n < 200) begin tick(); n++; end
        if (!in_ready) begin to = 1'b1; return; end
        in_a = a; in_x = x; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        while (!out_valid && lat < 300) begin tick(); lat++; end
        if (!out_valid) begin to = 1'b1; return; end
        p = out_p;
        repeat (stall) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b1; in_valid8 = 1'b0;
        #12;
        n_checks++;
        if ({in_ready, out_valid, mul_x} !== 3'b000 || out_p !== 64'd0 || mul_a !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b mul_x=%b out_p=%h mul_a=%h, required all zero",
                     in_ready, out_valid, mul_x, out_p, mul_a);
        end
        tick();
        rstn = 1'b1;
        for (int i = 0; i <= int'(WU); i++) begin
            if (i > 0) tick();
            n_checks++;
            if (in_ready !== (i == int'(WU))) begin
                n_fail++;
                $display("FAIL warmup_in_ready[%0d]: got %b, required %b", i, in_ready, i == int'(WU));
            end
            n_checks++;
            if (out_valid !== 1'b0 || mul_x !== 1'b0) begin
                n_fail++;
                $display("FAIL warmup_quiet[%0d]: out_valid=%b mul_x=%b, required 0 0", i, out_valid, mul_x);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        logic [63:0] p; int lat; bit to;
        run_op(32'd3, 32'd5, 0, p, lat, to);
        n_checks++;
        if (to || p !== 64'd15) begin
            n_fail++;
            $display("FAIL basic_product: got %0d (timeout=%b), required 15", p, to);
        end
        n_checks++;
        if (lat !== 66) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d edges, required 66", lat);
        end
        n_checks++;
        if (mul_a !== 32'd3) begin
            n_fail++;
            $display("FAIL basic_mul_a_held: got %h, required 3", mul_a);
        end
    endtask

    task automatic test_corners();
        logic [31:0] av[3] = '{32'hFFFF_FFFF, 32'h0, 32'h8000_0000};
        logic [31:0] xv[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
        logic [63:0] ev[3] = '{64'hFFFF_FFFE_0000_0001, 64'd0, 64'h1_0000_0000};
        logic [63:0] p; int lat; bit to;
        for (int i = 0; i < 3; i++) begin
            run_op(av[i], xv[i], 2, p, lat, to);
            n_checks++;
            if (to || p !== ev[i]) begin
                n_fail++;
                $display("FAIL corner[%0d]: got %h (timeout=%b), required %h", i, p, to, ev[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] p; int lat; bit to;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, p, lat, to);
        n_checks++;
        if (to || p !== 64'hFFFF_FFFE_0000_0001) begin
            n_fail++;
            $display("FAIL b2b_first: got %h, required fffffffe00000001", p);
        end
        run_op(32'd1, 32'd1, 0, p, lat, to);
        n_checks++;
        if (to || p !== 64'd1) begin
            n_fail++;
            $display("FAIL b2b_second: got %h, required 1", p);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp;
        int n;
        exp = 64'(32'h1234_5678) * 64'(32'h9ABC_DEF0);
        n = 0;
        while (!in_ready && n < 200) begin tick(); n++; end
        in_a = 32'h1234_5678; in_x = 32'h9ABC_DEF0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 300) begin tick(); n++; end
        n_checks++;
        if (out_valid !== 1'b1 || out_p !== exp) begin
            n_fail++;
            $display("FAIL bp_product: out_valid=%b out_p=%h, required 1 %h", out_valid, out_p, exp);
        end
        for (int i = 0; i < 50; i++) begin
            in_a = $urandom; in_x = $urandom; in_valid = 1'b1;
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_p !== exp || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: out_valid=%b out_p=%h in_ready=%b, required 1 %h 0",
                         i, out_valid, out_p, in_ready, exp);
            end
        end
        in_a = 32'd5; in_x = 32'd6; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0 || mul_a !== 32'd5) begin
            n_fail++;
            $display("FAIL bp_next_accept: in_ready=%b mul_a=%h, required 0 5", in_ready, mul_a);
        end
        n = 0;
        while (!out_valid && n < 300) begin tick(); n++; end
        n_checks++;
        if (out_p !== 64'd30) begin
            n_fail++;
            $display("FAIL bp_next_product: got %0d, required 30", out_p);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [63:0] p; int lat; bit to; int n;
        n = 0;
        while (!in_ready && n < 200) begin tick(); n++; end
        in_a = 32'hFFFF_FFFF; in_x = 32'hFFFF_FFFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready, mul_x} !== 3'b000 || mul_a !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_run: out_valid=%b in_ready=%b mul_x=%b mul_a=%h, required zeros",
                     out_valid, in_ready, mul_x, mul_a);
        end
        tick(); tick();
        rstn = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        n_checks++;
        if (n !== int'(WU)) begin
            n_fail++;
            $display("FAIL rerun_warmup: got %0d cycles, required %0d", n, WU);
        end
        in_a = 32'd7; in_x = 32'd9; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 300) begin tick(); n++; end
        n_checks++;
        if (out_valid !== 1'b1 || out_p !== 64'd63) begin
            n_fail++;
            $display("FAIL after_reset_product: out_valid=%b out_p=%0d, required 1 63", out_valid, out_p);
        end
        rstn = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_p !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_mid_done: out_valid=%b out_p=%h, required 0 0", out_valid, out_p);
        end
        tick();
        rstn = 1'b1;
        run_op(32'd2, 32'd3, 0, p, lat, to);
        n_checks++;
        if (to || p !== 64'd6) begin
            n_fail++;
            $display("FAIL recovery_product: got %0d (timeout=%b), required 6", p, to);
        end
    endtask

    task automatic test_random_32();
        logic [31:0] a, x; logic [63:0] p; int lat; bit to;
        for (int i = 0; i < 200; i++) begin
            a = $urandom; x = $urandom;
            if (i % 17 == 0) a = '1;
            if (i % 23 == 0) x = '1;
            run_op(a, x, int'($urandom_range(0, 3)), p, lat, to);
            n_checks++;
            if (to || p !== 64'(a) * 64'(x) || lat !== 66) begin
                n_fail++;
                $display("FAIL rand32[%0d]: %h*%h got %h lat %0d (timeout=%b), required %h lat 66",
                         i, a, x, p, lat, to, 64'(a) * 64'(x));
            end
        end
    endtask

    task automatic test_random_8();
        logic [7:0] a, x; logic [15:0] p; int lat; int n;
        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom); x = 8'($urandom);
            if (i < 2) begin a = 8'hFF; x = (i == 0) ? 8'hFF : 8'h00; end
            n = 0; lat = 0;
            while (!in_ready8 && n < 100) begin tick(); n++; end
            in_a8 = a; in_x8 = x; in_valid8 = 1'b1;
            tick();
            in_valid8 = 1'b0;
            while (!out_valid8 && lat < 100) begin tick(); lat++; end
            p = out_p8;
            repeat ($urandom_range(0, 3)) tick();
            out_ready8 = 1'b1;
            tick();
            out_ready8 = 1'b0;
            n_checks++;
            if (p !== 16'(a) * 16'(x) || lat !== 18) begin
                n_fail++;
                $display("FAIL rand8[%0d]: %h*%h got %h lat %0d, required %h lat 18",
                         i, a, x, p, lat, 16'(a) * 16'(x));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random_32();
        test_random_8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
